// File: rtl/mvu_pe_acc_ctrl_pkg.sv
// Shared types and helpers for the MVAU PE accumulation controller.
// Optional build macro: MVU_PE_ACC_SAT_EN (saturating accumulation, adds sat_flag).
package mvu_pe_pkg;

    typedef logic [1:0] op_sgn_t;

    localparam op_sgn_t OP_UU = 2'b00;
    localparam op_sgn_t OP_US = 2'b01;
    localparam op_sgn_t OP_SU = 2'b10;
    localparam op_sgn_t OP_SS = 2'b11;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } acc_state_e;

    // Smallest accumulator width that cannot overflow over a full fold.
    function automatic int acc_w(input int tdsti, input int simd, input int sf);
        return tdsti + $clog2(simd * sf);
    endfunction

endpackage

// File: rtl/mvu_pe_acc_ctrl_if.sv
// Product-in / result-out handshake bundle of the PE accumulation controller.
// Optional build macro: MVU_PE_ACC_SAT_EN adds the sat_flag signal.
interface mvu_pe_acc_ctrl_if #(
    parameter int SIMD  = 4,
    parameter int TDstI = 8,
    parameter int TO    = 16,
    parameter int SF    = 8
);
    import mvu_pe_pkg::*;

    logic                      in_v;
    logic                      in_rdy;
    logic [SIMD*TDstI-1:0]     in_prod;
    logic                      out_v;
    logic                      out_rdy;
    logic [TO-1:0]             out_acc;
    logic [$clog2(SF):0]       fold_cnt;
`ifdef MVU_PE_ACC_SAT_EN
    logic                      sat_flag;
`endif

    modport master (
        output in_v, in_prod, out_rdy,
        input  in_rdy, out_v, out_acc, fold_cnt
`ifdef MVU_PE_ACC_SAT_EN
        , input sat_flag
`endif
    );

    modport slave (
        input  in_v, in_prod, out_rdy,
        output in_rdy, out_v, out_acc, fold_cnt
`ifdef MVU_PE_ACC_SAT_EN
        , output sat_flag
`endif
    );

endinterface

// File: rtl/mvu_pe_acc_ctrl_simd_addtree.sv
// Combinational extend-and-sum of SIMD lane products to W bits (wraps modulo 2^W).
module mvu_pe_simd_addtree #(
    parameter int SIMD  = 4,
    parameter int TDstI = 8,
    parameter int W     = 16,
    parameter bit SGN   = 1'b0
) (
    input  logic [SIMD*TDstI-1:0] prod,
    output logic [W-1:0]          sum
);

    always_comb begin
        sum = '0;
        for (int i = 0; i < SIMD; i++) begin
            if (SGN)
                sum = sum + W'($signed(prod[i*TDstI +: TDstI]));
            else
                sum = sum + W'(prod[i*TDstI +: TDstI]);
        end
    end

endmodule

// File: rtl/mvu_pe_acc_ctrl.sv
// Accumulates SF beats of SIMD lane products into one dot product per fold.
// Optional build macro: MVU_PE_ACC_SAT_EN (saturating accumulate + sticky sat_flag).
module mvu_pe_acc_ctrl
    import mvu_pe_pkg::*;
#(
    parameter int      SIMD   = 4,
    parameter int      TDstI  = 8,
    parameter int      TO     = 16,
    parameter int      SF     = 8,
    parameter op_sgn_t OP_SGN = OP_UU
) (
    input  logic            aclk,
    input  logic            arst,
    mvu_pe_acc_ctrl_if.slave bus
);

    localparam bit IS_SGN = (OP_SGN != OP_UU);
    localparam int CNT_W  = $clog2(SF) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SF - 1);

`ifdef MVU_PE_ACC_SAT_EN
    // Lane sum is kept wide enough that only the accumulate step can clamp.
    localparam int SUM_W = TO + $clog2(SIMD) + 1;
    localparam logic signed [SUM_W:0] SAT_MAX = IS_SGN ?
        (SUM_W+1)'((64'sd1 <<< (TO-1)) - 64'sd1) : (SUM_W+1)'((64'sd1 <<< TO) - 64'sd1);
    localparam logic signed [SUM_W:0] SAT_MIN = IS_SGN ?
        (SUM_W+1)'(-(64'sd1 <<< (TO-1))) : '0;
`else
    localparam int SUM_W = TO;
`endif

    acc_state_e          state;
    logic [SUM_W-1:0]    lane_sum;
    logic [TO-1:0]       acc;
    logic [TO-1:0]       base;
    logic [TO-1:0]       next_acc;
    logic [TO-1:0]       out_acc;
    logic [CNT_W-1:0]    fold_cnt;
    logic                out_v;
    logic                in_rdy;
    logic                accept;

    mvu_pe_simd_addtree #(
        .SIMD  (SIMD),
        .TDstI (TDstI),
        .W     (SUM_W),
        .SGN   (IS_SGN)
    ) u_addtree (
        .prod (bus.in_prod),
        .sum  (lane_sum)
    );

    assign in_rdy = !arst && ((state == ACC) || bus.out_rdy);
    assign accept = bus.in_v && in_rdy;

`ifdef MVU_PE_ACC_SAT_EN
    logic signed [SUM_W:0] base_ext;
    logic signed [SUM_W:0] sum_ext;
    logic signed [SUM_W:0] wide;
    logic                  clamp;
    logic                  sat_run;
    logic                  sat_flag;

    // A beat taken in HOLD opens a new fold, so it accumulates onto zero.
    always_comb begin
        base     = (state == HOLD) ? '0 : acc;
        base_ext = IS_SGN ? (SUM_W+1)'($signed(base)) : (SUM_W+1)'(base);
        sum_ext  = IS_SGN ? (SUM_W+1)'($signed(lane_sum)) : (SUM_W+1)'(lane_sum);
        wide     = base_ext + sum_ext;
        clamp    = 1'b0;
        next_acc = wide[TO-1:0];
        if (wide > SAT_MAX) begin
            next_acc = SAT_MAX[TO-1:0];
            clamp    = 1'b1;
        end else if (wide < SAT_MIN) begin
            next_acc = SAT_MIN[TO-1:0];
            clamp    = 1'b1;
        end
    end

    assign bus.sat_flag = sat_flag;
`else
    always_comb begin
        base     = (state == HOLD) ? '0 : acc;
        next_acc = base + lane_sum;
    end
`endif

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state    <= ACC;
            acc      <= '0;
            fold_cnt <= '0;
            out_v    <= 1'b0;
            out_acc  <= '0;
`ifdef MVU_PE_ACC_SAT_EN
            sat_run  <= 1'b0;
            sat_flag <= 1'b0;
`endif
        end else begin
            case (state)
                ACC: begin
                    if (accept) begin
                        if (fold_cnt == LAST) begin
                            out_acc  <= next_acc;
                            acc      <= '0;
                            fold_cnt <= '0;
                            out_v    <= 1'b1;
                            state    <= HOLD;
`ifdef MVU_PE_ACC_SAT_EN
                            sat_flag <= sat_run | clamp;
                            sat_run  <= 1'b0;
`endif
                        end else begin
                            acc      <= next_acc;
                            fold_cnt <= fold_cnt + CNT_W'(1);
`ifdef MVU_PE_ACC_SAT_EN
                            sat_run  <= sat_run | clamp;
`endif
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_rdy) begin
                        if (accept) begin
                            if (SF == 1) begin
                                out_acc  <= next_acc;
`ifdef MVU_PE_ACC_SAT_EN
                                sat_flag <= clamp;
`endif
                            end else begin
                                acc      <= next_acc;
                                fold_cnt <= CNT_W'(1);
                                out_v    <= 1'b0;
                                state    <= ACC;
`ifdef MVU_PE_ACC_SAT_EN
                                sat_run  <= clamp;
                                sat_flag <= 1'b0;
`endif
                            end
                        end else begin
                            out_v <= 1'b0;
                            state <= ACC;
`ifdef MVU_PE_ACC_SAT_EN
                            sat_flag <= 1'b0;
`endif
                        end
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

    assign bus.in_rdy   = in_rdy;
    assign bus.out_v    = out_v;
    assign bus.out_acc  = out_acc;
    assign bus.fold_cnt = fold_cnt;

endmodule

// File: tb/tb_mvu_pe_acc_ctrl.sv
// Directed bench for mvu_pe_acc_ctrl: vector table on an unsigned SF=4 instance plus
// hand sequences for signed, SF=1, narrow-width wrap/saturate and mid-fold reset.
module tb_mvu_pe_acc_ctrl;
    import mvu_pe_pkg::*;

    logic clk;
    logic rst;

    int n_checks;
    int n_fails;

    typedef struct {
        logic        in_v;
        logic [31:0] prod;
        logic        out_rdy;
        logic        exp_in_rdy;
        logic        exp_out_v;
        logic [15:0] exp_acc;
        logic [2:0]  exp_cnt;
    } vec_t;

    vec_t vecs[$];

    mvu_pe_acc_ctrl_if #(.SIMD(4), .TDstI(8), .TO(16), .SF(4)) bus_a ();
    mvu_pe_acc_ctrl_if #(.SIMD(4), .TDstI(8), .TO(16), .SF(4)) bus_b ();
    mvu_pe_acc_ctrl_if #(.SIMD(4), .TDstI(8), .TO(16), .SF(1)) bus_c ();
    mvu_pe_acc_ctrl_if #(.SIMD(4), .TDstI(8), .TO(8),  .SF(4)) bus_d ();

    mvu_pe_acc_ctrl #(.SIMD(4), .TDstI(8), .TO(16), .SF(4), .OP_SGN(OP_UU))
        dut_a (.aclk(clk), .arst(rst), .bus(bus_a.slave));
    mvu_pe_acc_ctrl #(.SIMD(4), .TDstI(8), .TO(16), .SF(4), .OP_SGN(OP_SS))
        dut_b (.aclk(clk), .arst(rst), .bus(bus_b.slave));
    mvu_pe_acc_ctrl #(.SIMD(4), .TDstI(8), .TO(16), .SF(1), .OP_SGN(OP_UU))
        dut_c (.aclk(clk), .arst(rst), .bus(bus_c.slave));
    mvu_pe_acc_ctrl #(.SIMD(4), .TDstI(8), .TO(8),  .SF(4), .OP_SGN(OP_SS))
        dut_d (.aclk(clk), .arst(rst), .bus(bus_d.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic addVec(input logic in_v, input logic [31:0] prod, input logic out_rdy,
                          input logic exp_in_rdy, input logic exp_out_v,
                          input logic [15:0] exp_acc, input logic [2:0] exp_cnt);
        vec_t v;
        v.in_v = in_v; v.prod = prod; v.out_rdy = out_rdy;
        v.exp_in_rdy = exp_in_rdy; v.exp_out_v = exp_out_v;
        v.exp_acc = exp_acc; v.exp_cnt = exp_cnt;
        vecs.push_back(v);
    endtask

    // Drive one vector on instance A, check the handshake before the edge and state after it.
    task automatic applyStimulus(input vec_t v, input int idx);
        bus_a.in_v    = v.in_v;
        bus_a.in_prod = v.prod;
        bus_a.out_rdy = v.out_rdy;
        #1;
        checkOutput($sformatf("vec%0d in_rdy", idx), 32'(bus_a.in_rdy), 32'(v.exp_in_rdy));
        @(posedge clk);
        #1;
        checkOutput($sformatf("vec%0d out_v", idx), 32'(bus_a.out_v), 32'(v.exp_out_v));
        checkOutput($sformatf("vec%0d out_acc", idx), 32'(bus_a.out_acc), 32'(v.exp_acc));
        checkOutput($sformatf("vec%0d fold_cnt", idx), 32'(bus_a.fold_cnt), 32'(v.exp_cnt));
    endtask

    initial begin
        logic [31:0] p3, p1, pm, pf;
        logic [15:0] exp_sum;
        logic [7:0]  k8;
        n_checks = 0;
        n_fails  = 0;
        p3 = 32'h03030303;
        p1 = 32'h01010101;
        pm = 32'h01020304;
        pf = 32'hFFFFFFFF;

        bus_a.in_v = 0; bus_a.in_prod = '0; bus_a.out_rdy = 1;
        bus_b.in_v = 0; bus_b.in_prod = '0; bus_b.out_rdy = 1;
        bus_c.in_v = 0; bus_c.in_prod = '0; bus_c.out_rdy = 1;
        bus_d.in_v = 0; bus_d.in_prod = '0; bus_d.out_rdy = 1;

        // Two back-to-back folds of lane value 3, no bubble.
        for (int i = 0; i < 2; i++) begin
            addVec(1, p3, 1, 1, 0, 16'd48 * 16'(i), 3'd1);
            addVec(1, p3, 1, 1, 0, 16'd48 * 16'(i), 3'd2);
            addVec(1, p3, 1, 1, 0, 16'd48 * 16'(i), 3'd3);
            addVec(1, p3, 1, 1, 1, 16'd48, 3'd0);
        end
        for (int i = 0; i < 5; i++) addVec(1, p1, 0, 0, 1, 16'd48, 3'd0);
        addVec(1, pm, 1, 1, 0, 16'd48, 3'd1);
        addVec(0, pm, 1, 1, 0, 16'd48, 3'd1);
        addVec(0, pm, 0, 1, 0, 16'd48, 3'd1);
        addVec(1, pm, 0, 1, 0, 16'd48, 3'd2);
        addVec(1, pm, 1, 1, 0, 16'd48, 3'd3);
        addVec(1, pm, 1, 1, 1, 16'd40, 3'd0);
        addVec(0, pm, 1, 1, 0, 16'd40, 3'd0);
        addVec(0, '0, 1, 1, 0, 16'd40, 3'd0);
        addVec(1, pf, 1, 1, 0, 16'd40, 3'd1);
        addVec(1, pf, 1, 1, 0, 16'd40, 3'd2);
        addVec(1, pf, 1, 1, 0, 16'd40, 3'd3);
        addVec(1, pf, 1, 1, 1, 16'd4080, 3'd0);
        addVec(0, pf, 0, 0, 1, 16'd4080, 3'd0);
        addVec(0, pf, 1, 1, 0, 16'd4080, 3'd0);

        rst = 1'b1;
        #2;
        checkOutput("reset out_v", 32'(bus_a.out_v), 32'd0);
        checkOutput("reset in_rdy", 32'(bus_a.in_rdy), 32'd0);
        checkOutput("reset out_acc", 32'(bus_a.out_acc), 32'd0);
        checkOutput("reset fold_cnt", 32'(bus_a.fold_cnt), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 checkOutput("release in_rdy", 32'(bus_a.in_rdy), 32'd1);

        foreach (vecs[i]) applyStimulus(vecs[i], i);
        bus_a.in_v = 0;

        // Signed lanes of -1: four beats of sum -4 give -16.
        for (int i = 0; i < 4; i++) begin
            bus_b.in_v = 1; bus_b.in_prod = pf; bus_b.out_rdy = 1;
            @(posedge clk);
            #1;
            checkOutput($sformatf("signed beat%0d out_v", i), 32'(bus_b.out_v), (i == 3) ? 32'd1 : 32'd0);
        end
        checkOutput("signed out_acc", 32'(bus_b.out_acc), 32'h0000FFF0);
        bus_b.in_v = 0;
        @(posedge clk);
        #1 checkOutput("signed release out_v", 32'(bus_b.out_v), 32'd0);

        // Narrow 8-bit signed accumulator fed 0x7F on every lane.
        for (int i = 0; i < 4; i++) begin
            bus_d.in_v = 1; bus_d.in_prod = 32'h7F7F7F7F; bus_d.out_rdy = 1;
            @(posedge clk);
            #1;
        end
        bus_d.in_v = 0;
        checkOutput("narrow out_v", 32'(bus_d.out_v), 32'd1);
`ifdef MVU_PE_ACC_SAT_EN
        checkOutput("narrow sat out_acc", 32'(bus_d.out_acc), 32'h7F);
        checkOutput("narrow sat_flag", 32'(bus_d.sat_flag), 32'd1);
`else
        checkOutput("narrow wrap out_acc", 32'(bus_d.out_acc), 32'hF0);
`endif
        @(posedge clk);
        #1 checkOutput("narrow release out_v", 32'(bus_d.out_v), 32'd0);
`ifdef MVU_PE_ACC_SAT_EN
        checkOutput("narrow sat_flag cleared", 32'(bus_d.sat_flag), 32'd0);
`endif

        // SF=1: one result per cycle, each equal to the previous cycle's lane sum.
        for (int k = 0; k < 6; k++) begin
            k8 = 8'(k);
            bus_c.in_v = 1; bus_c.out_rdy = 1;
            bus_c.in_prod = {8'hF0, k8 + 8'd2, k8 + 8'd1, k8};
            exp_sum = 16'(3 * k + 3 + 240);
            #1 checkOutput($sformatf("sf1 beat%0d in_rdy", k), 32'(bus_c.in_rdy), 32'd1);
            @(posedge clk);
            #1;
            checkOutput($sformatf("sf1 beat%0d out_v", k), 32'(bus_c.out_v), 32'd1);
            checkOutput($sformatf("sf1 beat%0d out_acc", k), 32'(bus_c.out_acc), 32'(exp_sum));
        end
        bus_c.in_v = 0;
        @(posedge clk);
        #1 checkOutput("sf1 drain out_v", 32'(bus_c.out_v), 32'd0);

        // Reset between edges after two of four beats discards the partial fold.
        for (int i = 0; i < 2; i++) begin
            bus_a.in_v = 1; bus_a.in_prod = p3; bus_a.out_rdy = 1;
            @(posedge clk);
            #1;
        end
        checkOutput("pre-reset fold_cnt", 32'(bus_a.fold_cnt), 32'd2);
        bus_a.in_v = 0;
        #3 rst = 1'b1;
        #1;
        checkOutput("midreset out_v", 32'(bus_a.out_v), 32'd0);
        checkOutput("midreset fold_cnt", 32'(bus_a.fold_cnt), 32'd0);
        checkOutput("midreset out_acc", 32'(bus_a.out_acc), 32'd0);
        checkOutput("midreset in_rdy", 32'(bus_a.in_rdy), 32'd0);
        #1 rst = 1'b0;
        #1 checkOutput("midreset release in_rdy", 32'(bus_a.in_rdy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            bus_a.in_v = 1; bus_a.in_prod = p1; bus_a.out_rdy = 1;
            @(posedge clk);
            #1;
        end
        bus_a.in_v = 0;
        checkOutput("post-reset out_v", 32'(bus_a.out_v), 32'd1);
        checkOutput("post-reset out_acc", 32'(bus_a.out_acc), 32'd16);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
        $finish;
    end

endmodule
